// File: rtl/dm_mmio_pkg.sv
// rtl/dm_mmio_pkg.sv - shared decode constants and types for the data-memory/MMIO bridge
package dm_mmio_pkg;

    localparam logic [7:0] MMIO_BASE_HI = 8'hFF;

    localparam logic [7:0] OFS_TXDATA  = 8'h00;
    localparam logic [7:0] OFS_STATUS  = 8'h04;
    localparam logic [7:0] OFS_CYCLE   = 8'h08;
    localparam logic [7:0] OFS_INSTRET = 8'h0C;
    localparam logic [7:0] OFS_HALT    = 8'h10;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;

    typedef enum logic {TGT_RAM, TGT_MMIO} tgt_e;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - power-of-two byte FIFO feeding the serial sink; push while full is taken only with a pop
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    // Head forced to zero while empty so stale storage never leaks onto the sink bus
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dm_mmio_bridge.sv
// rtl/dm_mmio_bridge.sv - data RAM plus MMIO window (TX FIFO, status, halt); perf counters under DM_MMIO_PERF_EN
module dm_mmio_bridge
    import dm_mmio_pkg::*;
#(
    parameter int RAM_AW     = 14,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_w_en,
    input  logic [31:0] mem_w_data,
    output logic [31:0] mem_r_data,
    input  logic        valid_inst,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tgt_e              tgt;
    logic [7:0]        ofs;
    logic              mmio_wr;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [2**RAM_AW];

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              ovf;
    logic [31:0]       status;

    logic unused_addr;
    assign unused_addr = &{1'b0, mem_addr[31:16], mem_addr[1:0]};

    assign tgt     = (mem_addr[15:8] == MMIO_BASE_HI) ? TGT_MMIO : TGT_RAM;
    assign ofs     = {mem_addr[7:2], 2'b00};
    assign mmio_wr = (tgt == TGT_MMIO) && (mem_w_en != 4'b0000);
    assign ram_idx = mem_addr[RAM_AW+1:2];

    always_ff @(posedge clk) begin
        if (tgt == TGT_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_w_en[i]) ram[ram_idx][8*i +: 8] <= mem_w_data[8*i +: 8];
            end
        end
    end

    assign fifo_push = (tgt == TGT_MMIO) && (ofs == OFS_TXDATA) && mem_w_en[0];
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_w_data[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (tx_data)
    );

    // A push into a full FIFO only counts as an overflow when no pop frees a slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf  <= 1'b0;
            halt <= 1'b0;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop) ovf <= 1'b1;
            else if (mmio_wr && ofs == OFS_STATUS)   ovf <= 1'b0;
            if (mmio_wr && ofs == OFS_HALT && mem_w_data != 32'h0) halt <= 1'b1;
        end
    end

`ifdef DM_MMIO_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (mmio_wr && ofs == OFS_CYCLE && mem_w_en == 4'hF) cycle_cnt <= mem_w_data;
            else                                                 cycle_cnt <= cycle_cnt + 32'd1;
            if (mmio_wr && ofs == OFS_INSTRET && mem_w_en == 4'hF) instret_cnt <= mem_w_data;
            else if (valid_inst)                                   instret_cnt <= instret_cnt + 32'd1;
        end
    end
`else
    logic unused_valid;
    assign unused_valid = valid_inst;
`endif

    always_comb begin
        status                  = '0;
        status[ST_FULL]         = fifo_full;
        status[ST_EMPTY]        = fifo_empty;
        status[ST_OVF]          = ovf;
        status[ST_CNT_LO +: 4]  = 4'(fifo_count);
        mem_r_data              = '0;
        if (tgt == TGT_RAM) begin
            mem_r_data = ram[ram_idx];
        end else begin
            case (ofs)
                OFS_STATUS:  mem_r_data = status;
`ifdef DM_MMIO_PERF_EN
                OFS_CYCLE:   mem_r_data = cycle_cnt;
                OFS_INSTRET: mem_r_data = instret_cnt;
`endif
                OFS_HALT:    mem_r_data = {31'b0, halt};
                default:     mem_r_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// tb/tb_dm_mmio_bridge.sv - directed bench with a queue/array reference model for dm_mmio_bridge
module tb_dm_mmio_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'h0000_FF04;
    logic [3:0]  mem_w_en = 4'h0;
    logic [31:0] mem_w_data = 32'h0;
    logic [31:0] mem_r_data;
    logic        valid_inst = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halt;

    int vectors = 0;
    int miscompares = 0;

    dm_mmio_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_w_en   (mem_w_en),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .valid_inst (valid_inst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  q[$];
    logic [31:0] m_ram [int];
    logic [3:0]  m_known [int];
    logic        m_ovf = 1'b0;
    logic        m_halt = 1'b0;
    logic [31:0] m_cyc = 32'h0;
    logic [31:0] m_ins = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int          w;
        logic        mmio;
        logic [7:0]  o;
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_halt = 1'b0;
            m_cyc  = 32'h0;
            m_ins  = 32'h0;
        end else begin
            mmio = (mem_addr[15:8] == 8'hFF);
            o    = {mem_addr[7:2], 2'b00};
            w    = int'(mem_addr[15:2]);
            if (!mmio && mem_w_en != 4'h0) begin
                if (!m_ram.exists(w)) begin
                    m_ram[w]   = 32'h0;
                    m_known[w] = 4'h0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (mem_w_en[i]) begin
                        m_ram[w][8*i +: 8] = mem_w_data[8*i +: 8];
                        m_known[w][i]      = 1'b1;
                    end
                end
            end
            if (q.size() > 0 && tx_ready) void'(q.pop_front());
            if (mmio && o == 8'h00 && mem_w_en[0]) begin
                if (q.size() < 8) q.push_back(mem_w_data[7:0]);
                else              m_ovf = 1'b1;
            end
            if (mmio && o == 8'h04 && mem_w_en != 4'h0) m_ovf = 1'b0;
            if (mmio && o == 8'h10 && mem_w_en != 4'h0 && mem_w_data != 0) m_halt = 1'b1;
            if (mmio && o == 8'h08 && mem_w_en == 4'hF) m_cyc = mem_w_data;
            else                                        m_cyc = m_cyc + 1;
            if (mmio && o == 8'h0C && mem_w_en == 4'hF) m_ins = mem_w_data;
            else if (valid_inst)                        m_ins = m_ins + 1;
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic known, output logic [31:0] v);
        int         w;
        logic [7:0] o;
        known = 1'b1;
        v     = 32'h0;
        o     = {a[7:2], 2'b00};
        w     = int'(a[15:2]);
        if (a[15:8] == 8'hFF) begin
            case (o)
                8'h04: v = {24'h0, 4'(q.size()), 1'b0, m_ovf, (q.size() == 0), (q.size() == 8)};
`ifdef DM_MMIO_PERF_EN
                8'h08: v = m_cyc;
                8'h0C: v = m_ins;
`endif
                8'h10: v = {31'h0, m_halt};
                default: v = 32'h0;
            endcase
        end else if (m_ram.exists(w) && m_known[w] == 4'hF) begin
            v = m_ram[w];
        end else begin
            known = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        logic        k;
        logic [31:0] v;
        @(negedge clk);
        model_read(mem_addr, k, v);
        if (k) check("model_rdata", mem_r_data, v);
        check("model_tx_valid", {31'h0, tx_valid}, {31'h0, (q.size() > 0)});
        if (q.size() > 0) check("model_tx_data", {24'h0, tx_data}, {24'h0, q[0]});
        check("model_halt", {31'h0, halt}, {31'h0, m_halt});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        step();
        mem_addr   = a;
        mem_w_data = d;
        mem_w_en   = en;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        step();
        mem_addr = a;
        mem_w_en = 4'h0;
        #2;
        check(name, mem_r_data, exp);
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        #2;
        check("rst_status", mem_r_data, 32'h0000_0002);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_halt", {31'h0, halt}, 32'h0);
        step();
        step();
        rst        = 1'b0;
        valid_inst = 1'b1;
        repeat (10) step();
        valid_inst = 1'b0;
`ifdef DM_MMIO_PERF_EN
        rd_chk("instret_10", 32'h0000_FF0C, 32'd10);
`else
        rd_chk("instret_absent", 32'h0000_FF0C, 32'h0);
`endif
        wr(32'h0000_FF08, 32'hFFFF_FFFE, 4'hF);
        step();
        mem_w_en = 4'h0;
        step();
        step();
        #2;
        check("cycle_wrap", mem_r_data, 32'h0);

        // RAM byte lanes and read-during-write
        wr(32'h0000_0100, 32'hAABB_CCDD, 4'hF);
        wr(32'h0000_0100, 32'h0000_0011, 4'h1);
        rd_chk("ram_lane0", 32'h0000_0100, 32'hAABB_CC11);
        rd_chk("ram_addr_lsb", 32'h0000_0103, 32'hAABB_CC11);
        wr(32'h0000_0200, 32'h1234_5678, 4'hF);
        wr(32'h0000_0200, 32'h0000_0000, 4'hF);
        #2;
        check("ram_rdw_old", mem_r_data, 32'h1234_5678);
        rd_chk("ram_rdw_new", 32'h0000_0200, 32'h0);

        // Fill past full, then drain
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(32'h0000_FF00, i, 4'h1);
        rd_chk("status_full_ovf", 32'h0000_FF04, 32'h85);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_byte", {24'h0, tx_data}, i);
            step();
            #2;
        end
        check("drain_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd_chk("status_ovf_empty", 32'h0000_FF04, 32'h06);
        wr(32'h0000_FF04, 32'h0, 4'hF);
        rd_chk("status_ovf_clr", 32'h0000_FF04, 32'h02);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) wr(32'h0000_FF00, 32'h10 + i, 4'h1);
        wr(32'h0000_FF00, 32'h55, 4'h1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        mem_w_en = 4'h0;
        mem_addr = 32'h0000_FF04;
        #2;
        check("full_push_pop", mem_r_data, 32'h81);
        drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_pp", {24'h0, tx_data}, {24'h0, drain_exp[i]});
            step();
            #2;
        end
        // Push and pop together while empty
        wr(32'h0000_FF00, 32'h66, 4'h1);
        step();
        mem_w_en = 4'h0;
        #2;
        check("empty_pp_valid", {31'h0, tx_valid}, 32'h1);
        check("empty_pp_data", {24'h0, tx_data}, 32'h66);
        step();
        #2;
        check("empty_pp_drained", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Halt
        wr(32'h0000_FF10, 32'h0, 4'hF);
        wr(32'h0000_FF10, 32'h1, 4'hF);
        #2;
        check("halt_not_yet", {31'h0, halt}, 32'h0);
        step();
        mem_w_en = 4'h0;
        #2;
        check("halt_set", {31'h0, halt}, 32'h1);
        rd_chk("halt_read", 32'h0000_FF10, 32'h1);

        // Reset mid-operation with bytes queued
        wr(32'h0000_0300, 32'hCAFE_BABE, 4'hF);
        for (int i = 0; i < 3; i++) wr(32'h0000_FF00, 32'hA1 + i, 4'h1);
        step();
        mem_w_en = 4'h0;
        #2;
        check("queued_valid", {31'h0, tx_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_mid_halt", {31'h0, halt}, 32'h0);
        step();
        step();
        rst = 1'b0;
        rd_chk("ram_kept_300", 32'h0000_0300, 32'hCAFE_BABE);
        rd_chk("ram_kept_100", 32'h0000_0100, 32'hAABB_CC11);
        rd_chk("status_after_rst", 32'h0000_FF04, 32'h02);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
